// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Counter must reach the value `w` itself, hence w+1 distinct values.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_seq_nbits_if.sv
// Request/response bundle for mult_seq_nbits: operands and start in, status and product out.
interface mult_seq_nbits_if #(
    parameter int width = 8
);
    logic                 start;
    logic                 sgn;
    logic [width-1:0]     a;
    logic [width-1:0]     b;
    logic                 ready;
    logic                 done;
    logic [2*width-1:0]   s;

    modport master (output start, sgn, a, b, input ready, done, s);
    modport slave  (input start, sgn, a, b, output ready, done, s);
endinterface

// File: rtl/mult_seq_nbits.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, unsigned or two's-complement.
module mult_seq_nbits
    import mult_pkg::*;
#(
    parameter int width = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [width-1:0]     a_i,
    input  logic [width-1:0]     b_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic [2*width-1:0]   s_o
);

    localparam int CW = cnt_width(width);

    typedef logic [2*width-1:0] prod_t;

    state_e           state_q, state_d;
    logic [width-1:0] mcand_q, mcand_d;
    logic [width-1:0] mplier_q, mplier_d;
    prod_t            acc_q, acc_d;
    prod_t            s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    // The most-negative value negates to itself, which read unsigned is 2^(width-1).
    function automatic logic [width-1:0] magnitude(input logic [width-1:0] v, input logic sgn);
        return (sgn && v[width-1]) ? -v : v;
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d  = magnitude(a_i, signed_i);
                    mplier_d = magnitude(b_i, signed_i);
                    neg_d    = signed_i & (a_i[width-1] ^ b_i[width-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + (prod_t'(mcand_q) << cnt_q);
                end
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(width - 1)) begin
                    state_d = DONE;
                    s_d     = neg_q ? -acc_d : acc_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignment so all updates read pre-edge values.
        if (!rst_n_i) begin
            // NOTE: everything here is plain flops, so resetting all of it is cheap and keeps s_o defined.
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign s_o     = s_q;

endmodule

// File: tb/tb_mult_seq_nbits.sv
// Scoreboard bench for mult_seq_nbits at widths 8, 4 and 16 against an integer-arithmetic model.
module tb_mult_seq_nbits;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    localparam int W [3] = '{8, 4, 16};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exq [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_seq_nbits_if #(.width(8))  i8 ();
    mult_seq_nbits_if #(.width(4))  i4 ();
    mult_seq_nbits_if #(.width(16)) i16 ();

    mult_seq_nbits #(.width(8)) u8 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(i8.start), .signed_i(i8.sgn),
        .a_i(i8.a), .b_i(i8.b), .ready_o(i8.ready), .done_o(i8.done), .s_o(i8.s));
    mult_seq_nbits #(.width(4)) u4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(i4.start), .signed_i(i4.sgn),
        .a_i(i4.a), .b_i(i4.b), .ready_o(i4.ready), .done_o(i4.done), .s_o(i4.s));
    mult_seq_nbits #(.width(16)) u16 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(i16.start), .signed_i(i16.sgn),
        .a_i(i16.a), .b_i(i16.b), .ready_o(i16.ready), .done_o(i16.done), .s_o(i16.s));

    // Reference: interpret operands as integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_prod(input int w, input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'({32'd0, a} & mask);
        sb = longint'({32'd0, b} & mask);
        if (sg && a[w-1]) sa = sa - (64'sd1 <<< w);
        if (sg && b[w-1]) sb = sb - (64'sd1 <<< w);
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(sa * sb) & mask;
    endfunction

    function automatic logic get_ready(input int d);
        case (d)
            0:       return i8.ready;
            1:       return i4.ready;
            default: return i16.ready;
        endcase
    endfunction

    function automatic logic get_done(input int d);
        case (d)
            0:       return i8.done;
            1:       return i4.done;
            default: return i16.done;
        endcase
    endfunction

    function automatic logic [63:0] get_s(input int d);
        case (d)
            0:       return 64'(i8.s);
            1:       return 64'(i4.s);
            default: return 64'(i16.s);
        endcase
    endfunction

    task automatic drive(input int d, input logic st, input logic sg, input logic [31:0] a, input logic [31:0] b);
        case (d)
            0:       begin i8.start = st;  i8.sgn = sg;  i8.a = a[7:0];   i8.b = b[7:0];   end
            1:       begin i4.start = st;  i4.sgn = sg;  i4.a = a[3:0];   i4.b = b[3:0];   end
            default: begin i16.start = st; i16.sgn = sg; i16.a = a[15:0]; i16.b = b[15:0]; end
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Wait for ready, issue one operation, then scramble operands after the accepting edge.
    task automatic op(input int d, input logic sg, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!get_ready(d) && t < 200);
        if (!get_ready(d)) begin
            n_checks++;
            $display("FAIL w%0d ready_timeout: ready_o still 0 after %0d cycles, required 1", W[d], t);
            return;
        end
        drive(d, 1'b1, sg, a, b);
        @(posedge clk);
        #1;
        exq[d].push_back('{prod: ref_prod(W[d], sg, a, b), cyc: cyc + W[d]});
        drive(d, 1'b0, 1'($urandom), $urandom, $urandom);
    endtask

    task automatic drain(input int d);
        int t = 0;
        while (exq[d].size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exq[d].size() > 0) begin
            n_checks++;
            $display("FAIL w%0d drain_timeout: %0d results outstanding, required 0", W[d], exq[d].size());
            exq[d].delete();
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (get_done(d)) begin
                    if (exq[d].size() == 0) begin
                        n_checks++;
                        $display("FAIL w%0d spurious_done: got done_o=1, required no pulse (cycle %0d)", W[d], cyc);
                    end else begin
                        exp_t e;
                        e = exq[d].pop_front();
                        check($sformatf("w%0d product", W[d]), get_s(d), e.prod);
                        check($sformatf("w%0d done_cycle", W[d]), 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin
        int c;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready_o", 64'(get_ready(0)), 64'd1);
        check("reset done_o", 64'(get_done(0)), 64'd0);
        check("reset s_o", get_s(0), 64'd0);
        check("reset w16 ready_o", 64'(get_ready(2)), 64'd1);
        rst_n = 1'b1;

        // Directed width-8 corner operands
        op(0, 1'b0, 32'hFF, 32'hFF);
        op(0, 1'b1, 32'h80, 32'h80);
        op(0, 1'b1, 32'hFD, 32'h05);
        op(0, 1'b0, 32'h00, 32'hA5);
        op(0, 1'b0, 32'hFD, 32'h05);
        drain(0);
        repeat (5) @(negedge clk);
        check("s_o held in idle", get_s(0), 64'h04F1);

        op(0, 1'b0, 32'h12, 32'h34);
        repeat (3) @(posedge clk);
        #1;
        check("s_o held during calc", get_s(0), 64'h04F1);
        drain(0);

        // Second start in cycle 4 of an operation must be ignored
        op(0, 1'b0, 32'h37, 32'hC9);
        repeat (3) @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b1, 32'h55, 32'hAA);
        check("ready_o low in calc", 64'(get_ready(0)), 64'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drain(0);
        repeat (4) @(negedge clk);
        check("ready_o after ignored start", 64'(get_ready(0)), 64'd1);
        check("s_o after ignored start", get_s(0), ref_prod(8, 1'b0, 32'h37, 32'hC9));

        // Reset asserted in cycle 5 of an operation aborts it
        op(0, 1'b0, 32'hFF, 32'hFF);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(exq[0].pop_front());
        @(posedge clk);
        @(negedge clk);
        check("abort ready_o", 64'(get_ready(0)), 64'd1);
        check("abort s_o", get_s(0), 64'd0);
        check("abort done_o", 64'(get_done(0)), 64'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // start_i held high: a new operation every width+2 cycles
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!get_ready(0) && c < 50);
        drive(0, 1'b1, 1'b1, 32'hA3, 32'h7E);
        @(posedge clk);
        #1;
        c = cyc;
        for (int k = 0; k < 3; k++)
            exq[0].push_back('{prod: ref_prod(8, 1'b1, 32'hA3, 32'h7E), cyc: c + k * 10 + 8});
        repeat (20) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drain(0);

        // Randomized and exhaustive traffic on all three widths concurrently
        fork
            begin
                for (int sg = 0; sg < 2; sg++)
                    for (int a = 0; a < 16; a++)
                        for (int b = 0; b < 16; b++)
                            op(1, 1'(sg), 32'(a), 32'(b));
            end
            begin
                for (int n = 0; n < 150; n++) op(2, 1'($urandom), $urandom, $urandom);
            end
            begin
                for (int n = 0; n < 80; n++) op(0, 1'($urandom), $urandom, $urandom);
            end
        join
        for (int d = 0; d < 3; d++) drain(d);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_seq_nbits.md
MULT_SEQ_NBITS -- requirements
Module: mult_seq_nbits

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the operand width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start_i, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL have port signed_i, input, 1 bit: operand mode, 1 = two's-complement, 0 = unsigned; sampled with start_i.
REQ-006 The block SHALL have ports a_i and b_i, input, width bits each: multiplicand and multiplier; sampled with start_i.
REQ-007 The block SHALL have port ready_o, output, 1 bit: high when idle and able to accept start_i.
REQ-008 The block SHALL have port done_o, output, 1 bit: one-cycle pulse marking s_o valid.
REQ-009 The block SHALL have port s_o, output, 2*width bits: the product.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-011 In IDLE, ready_o SHALL be 1; start_i=1 at a rising edge SHALL capture a_i, b_i and signed_i, clear the accumulator, load the iteration counter with 0, and move to CALC.
REQ-012 In signed mode, operands SHALL be captured as magnitudes (two's-complement negation if the MSB is set), with result sign = sign(a) XOR sign(b).
REQ-013 Magnitude of the most-negative value (e.g. -128 for width 8) SHALL be handled as the unsigned value 2^(width-1) without overflow.
REQ-014 Each CALC cycle SHALL examine one multiplier bit, LSB first; if set, the multiplicand shifted left by the counter value SHALL be added to a 2*width-bit accumulator, and the counter SHALL increment.
REQ-015 After exactly width CALC cycles, the FSM SHALL move to DONE; the counter SHALL be ceil(log2(width+1)) bits and SHALL not wrap within an operation.
REQ-016 On entry to DONE, s_o SHALL be loaded with the accumulator, negated modulo 2^(2*width) if the result sign is 1 in signed mode.
REQ-017 In DONE, done_o SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-018 Latency: with start_i accepted in cycle 0, done_o SHALL be high in cycle width+1 and ready_o high again in cycle width+2.
REQ-019 s_o SHALL hold its value from DONE until the next result is loaded, and SHALL not change during CALC.
REQ-020 start_i while in CALC or DONE SHALL be ignored, with no queuing.
REQ-021 A start_i held high continuously SHALL start a new operation on each return to IDLE (back-to-back period width+2 cycles).
REQ-022 Changes on a_i, b_i or signed_i after the accepting edge SHALL not affect the in-flight operation.
REQ-023 The product SHALL be exact for all operand pairs in both modes; no truncation SHALL occur.

Reset
REQ-024 With rst_n_i=0 at a rising edge, the block SHALL reset to state IDLE, with ready_o=1, done_o=0, s_o=0, accumulator=0 and counter=0.
REQ-025 Reset SHALL take priority over start_i, and reset during CALC or DONE SHALL abort the operation with no done_o pulse.

Structure
REQ-026 A shared package mult_pkg SHALL hold the state enum type (IDLE, CALC, DONE) and a function returning the counter width for a given width.
REQ-027 The block SHALL be a single module without sub-modules; the add/shift datapath and FSM SHALL live in one module with separate sequential and next-state logic.

Verification
REQ-028 The bench SHALL cover: width=8, unsigned, a=0xFF, b=0xFF, start in cycle 0 -> done_o in cycle 9, s_o=0xFE01.
REQ-029 The bench SHALL cover: width=8, signed, a=0x80, b=0x80 -> s_o=0x4000; then a=0xFD (-3), b=0x05 -> s_o=0xFFF1.
REQ-030 The bench SHALL cover: width=8, unsigned, a=0xFD, b=0x05 -> s_o=0x04F1; then a=0x00, b=0xA5 -> s_o=0x0000.
REQ-031 The bench SHALL cover: start_i pulsed again in cycle 4 with different operands -> ignored, first result intact, exactly one done_o pulse.
REQ-032 The bench SHALL cover: rst_n_i=0 in cycle 5 of an operation -> following cycle ready_o=1, s_o=0, with no done_o pulse afterwards.
REQ-033 The bench SHALL cover: width=4 and width=16 exhaustive/random signed and unsigned operands against a behavioural product -> zero mismatches, latency width+1.
